if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage. Drives if_pc_o/if_inst_o into the IF/ID pipeline register.
//  Fetches 32-bit instructions over the byte-wide memory-controller port, four bytes per
//  instruction, through a small direct-mapped instruction cache.
//  Raises a stall request while a fetch is in progress.
//  Honours downstream stall_i and EX-stage redirects (jump_i/jump_addr_i).
// PARAMETERS
//  ICACHE_IDX_W  6   log2 of cache lines; one 32-bit word per line (64 lines)
//  RESET_PC      0   PC value loaded on reset
// PORTS
//  clk          in   1              clock; all state updates on posedge
//  rst          in   1              synchronous reset, active-high
//  mem_req_o    out  1              byte-read request to memory controller
//  mem_addr_o   out  `AddrLen       byte address of requested byte
//  mem_ready_i  in   1              requested byte is valid on mem_data_i this cycle
//  mem_data_i   in   8              returned byte
//  if_pc_o      out  `AddrLen       PC handed to IF/ID
//  if_inst_o    out  `InstLen       instruction handed to IF/ID; ZERO_WORD = bubble
//  stall_req_o  out  1              to stall_ctrl: IF not ready, freeze PC/IF
//  stall_i      in   `PipelineNum   from stall_ctrl; bit 0 = PC/IF stalled
//  jump_i       in   1              EX redirect, single-cycle pulse
//  jump_addr_i  in   `AddrLen       redirect target, valid when jump_i=1
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - pc_q<=RESET_PC; state<=FETCH; byte_cnt<=0; inst_q<=ZERO_WORD; all cache valid bits cleared.
//   - Outputs while rst is high: mem_req_o=0, if_pc_o=if_inst_o=ZERO_WORD, stall_req_o=0.
//  States:
//   - FETCH: stall_req_o=1.
//   - HOLD:  stall_req_o=0; instruction ready.
//  FETCH, byte_cnt==0, cache hit on pc_q:
//   - No mem_req_o.
//   - inst_q<=cache word; next state HOLD. Hit path = 1 cycle.
//  FETCH, miss or byte_cnt!=0:
//   - mem_req_o=1; mem_addr_o=pc_q+byte_cnt. Request is held until mem_ready_i.
//   - On mem_ready_i: inst_q[8*byte_cnt+7 -: 8]<=mem_data_i (little-endian); byte_cnt++.
//   - When byte_cnt==3 and mem_ready_i: write the full word into the cache (tag=pc_q upper bits,
//     idx=pc_q[ICACHE_IDX_W+1:2]); byte_cnt<=0; next state HOLD.
//  HOLD:
//   - if_pc_o=pc_q; if_inst_o=inst_q. Outside HOLD, both outputs are ZERO_WORD.
//   - stall_i[0]==0: pc_q<=pc_q+4 (wraps mod 2^32); next state FETCH.
//   - stall_i[0]==1: hold all state and outputs.
//  jump_i=1 has priority over everything except rst, in any state:
//   - pc_q<=jump_addr_i; byte_cnt<=0; next state FETCH.
//   - mem_req_o is forced 0 that cycle; a byte returned in that cycle is discarded.
//   - A cache fill completing in the same cycle still writes (the data is correct for its own PC).
//  The memory controller tolerates withdrawal of a request without a prior ready.
//  Only one outstanding request; mem_addr_o stays stable while mem_req_o=1.
//  jump_addr_i is assumed word-aligned; no misalignment trap is raised.
// STRUCTURE
//  Shared defines package (existing `defines`):
//   - AddrLen, InstLen, ZERO_WORD, PipelineNum, ResetEnable.
//   - New: IcacheIdxW, state encodings IF_FETCH/IF_HOLD.
//  Sub-module if_icache:
//   - Arrays valid/tag/data.
//   - Combinational read (hit, rdata) on raddr.
//   - Synchronous write port (we, waddr, wdata).
//   - Synchronous reset clears valid bits only.
//  if_stage holds the FSM, byte counter, PC and assembly register.
// TESTING
//  1 Cold miss: reset; memory holds 0x00500093 at 0 with 1-cycle ready.
//    -> 4 requests at addr 0,1,2,3; stall_req_o=1 throughout.
//    -> then HOLD with if_pc_o=0, if_inst_o=0x00500093.
//  2 Hit: loop re-executes PC 0 via jump_i with jump_addr_i=0.
//    -> no mem_req_o; HOLD reached 1 cycle after FETCH with the same instruction.
//  3 Downstream stall: in HOLD, stall_i[0]=1 for 3 cycles.
//    -> outputs and pc frozen; release -> pc=4, FETCH.
//  4 Jump mid-fetch: jump_i with addr 0x100 after byte 1 is returned.
//    -> mem_req_o=0 that cycle.
//    -> next request addr 0x100; the partial word is never cached or output.
//  5 Slow memory: mem_ready_i delayed 5 cycles per byte.
//    -> mem_addr_o stable while waiting; assembled word correct.
//  6 Reset mid-fetch: rst after byte 2 at pc 0x40.
//    -> pc=0, cache empty (next fetch of 0x40 misses).
//    -> no stale output.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, constants and IF state encodings for the fetch stage.
package if_stage_pkg;
  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int PIPELINE_NUM = 6;
  localparam int ICACHE_IDX_W_DEF = 6;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic RESET_ENABLE = 1'b1;
  typedef enum logic {IF_FETCH, IF_HOLD} if_state_e;
endpackage

// File: rtl/if_stage_icache.sv
// if_stage_icache: direct-mapped, one word per line, combinational read, synchronous write.
module if_stage_icache
  import if_stage_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEF,
  parameter int TAG_W = ADDR_LEN - IDX_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    ridx,
  input  logic [TAG_W-1:0]    rtag,
  output logic                hit,
  output logic [INST_LEN-1:0] rdata,
  input  logic                we,
  input  logic [IDX_W-1:0]    widx,
  input  logic [TAG_W-1:0]    wtag,
  input  logic [INST_LEN-1:0] wdata
);
  localparam int LINES = 1 << IDX_W;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_LEN-1:0] data_q [LINES];
  assign hit = valid_q[ridx] && tag_q[ridx] == rtag;
  assign rdata = data_q[ridx];
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) valid_q <= '0;
    else if (we) valid_q[widx] <= 1'b1;
    if (we) begin
      tag_q[widx] <= wtag;
      data_q[widx] <= wdata;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch assembling 32-bit words from a byte-wide port behind an icache.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_req_o,
  output logic [ADDR_LEN-1:0]     mem_addr_o,
  input  logic                    mem_ready_i,
  input  logic [7:0]              mem_data_i,
  output logic [ADDR_LEN-1:0]     if_pc_o,
  output logic [INST_LEN-1:0]     if_inst_o,
  output logic                    stall_req_o,
  input  logic [PIPELINE_NUM-1:0] stall_i,
  input  logic                    jump_i,
  input  logic [ADDR_LEN-1:0]     jump_addr_i
);
  localparam int TAG_W = ADDR_LEN - ICACHE_IDX_W - 2;
  if_state_e           state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [INST_LEN-1:0] inst_q, inst_d, c_rdata;
  logic [1:0]          cnt_q, cnt_d;
  logic                fetch, hit, use_cache, fill, in_rst, unused_stall;
  assign unused_stall = ^stall_i[PIPELINE_NUM-1:1];
  assign in_rst = rst == RESET_ENABLE;
  assign fetch = state_q == IF_FETCH;
  assign use_cache = fetch && cnt_q == 2'd0 && hit;
  // A completing fill is written even under a jump: the word belongs to pc_q, not the target.
  assign fill = fetch && mem_ready_i && &cnt_q;
  assign mem_req_o = !in_rst && fetch && !use_cache && !jump_i;
  assign mem_addr_o = pc_q + {{(ADDR_LEN-2){1'b0}}, cnt_q};
  assign stall_req_o = !in_rst && fetch;
  assign if_pc_o = (!in_rst && state_q == IF_HOLD) ? pc_q : ZERO_WORD;
  assign if_inst_o = (!in_rst && state_q == IF_HOLD) ? inst_q : ZERO_WORD;
  if_stage_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
    .clk   (clk),
    .rst   (rst),
    .ridx  (pc_q[ICACHE_IDX_W+1:2]),
    .rtag  (pc_q[ADDR_LEN-1:ICACHE_IDX_W+2]),
    .hit   (hit),
    .rdata (c_rdata),
    .we    (fill),
    .widx  (pc_q[ICACHE_IDX_W+1:2]),
    .wtag  (pc_q[ADDR_LEN-1:ICACHE_IDX_W+2]),
    .wdata ({mem_data_i, inst_q[23:0]})
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    inst_d = inst_q;
    if (jump_i) begin
      pc_d = jump_addr_i;
      cnt_d = 2'd0;
      state_d = IF_FETCH;
    end else if (fetch) begin
      if (use_cache) begin
        inst_d = c_rdata;
        state_d = IF_HOLD;
      end else if (mem_ready_i) begin
        inst_d[8*cnt_q +: 8] = mem_data_i;
        cnt_d = cnt_q + 2'd1;
        state_d = &cnt_q ? IF_HOLD : IF_FETCH;
      end
    end else if (!stall_i[0]) begin
      pc_d = pc_q + 32'd4;
      state_d = IF_FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q <= IF_FETCH;
      pc_q <= RESET_PC;
      cnt_q <= 2'd0;
      inst_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      inst_q <= inst_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage against a byte memory with programmable latency.
module tb_if_stage;
  import if_stage_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, mem_ready_i = 1'b0, jump_i = 1'b0;
  logic        mem_req_o, stall_req_o;
  logic [7:0]  mem_data_i = 8'h0;
  logic [31:0] mem_addr_o, if_pc_o, if_inst_o, jump_addr_i = 32'h0;
  logic [5:0]  stall_i = 6'h1;
  logic [7:0]  mem [0:511];
  logic [31:0] xfer_q [$];
  logic        prev_req = 1'b0, prev_rdy = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          mem_lat = 0, wait_cnt = 0, unstable = 0, n_chk = 0, n_pass = 0, cyc;

  if_stage dut (
    .clk(clk), .rst(rst), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .stall_req_o(stall_req_o), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i)
  );

  always #5 clk = ~clk;

  // Byte memory: answers a pending request after mem_lat idle cycles, for one cycle.
  initial forever begin
    @(negedge clk);
    if (mem_req_o && wait_cnt >= mem_lat) begin
      mem_ready_i = 1'b1;
      mem_data_i = mem[mem_addr_o[8:0]];
      wait_cnt = 0;
    end else begin
      mem_ready_i = 1'b0;
      wait_cnt = mem_req_o ? wait_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (mem_req_o && mem_ready_i) xfer_q.push_back(mem_addr_o);
    if (prev_req && !prev_rdy && mem_req_o && mem_addr_o != prev_addr) unstable <= unstable + 1;
    prev_req <= mem_req_o;
    prev_rdy <= mem_ready_i;
    prev_addr <= mem_addr_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a+i] = w[8*i +: 8];
  endtask

  task automatic run_until_hold(input int lim, output int c);
    c = 0;
    while (stall_req_o && c < lim) begin
      tick();
      c++;
    end
  endtask

  task automatic jump_to(input logic [31:0] a);
    jump_i = 1'b1;
    jump_addr_i = a;
    #1;
    chk("jump_req_low", {31'b0, mem_req_o}, 32'd0);
    tick();
    jump_i = 1'b0;
    #1;
  endtask

  task automatic chk_xfers(input string tag, input logic [31:0] base);
    chk({tag, "_nxfer"}, xfer_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < xfer_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), xfer_q[i], base + i);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_stall_req"}, {31'b0, stall_req_o}, 32'd0);
    chk({tag, "_pc"}, if_pc_o, pc);
    chk({tag, "_inst"}, if_inst_o, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h0;
    put_word(32'h000, 32'h00500093);
    put_word(32'h004, 32'h11223344);
    put_word(32'h040, 32'hCAFEF00D);
    put_word(32'h100, 32'hDEADBEEF);
    put_word(32'h1FC, 32'hA5A5_5A5A);
    tick();
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_stall_req", {31'b0, stall_req_o}, 32'd0);
    chk("rst_pc", if_pc_o, ZERO_WORD);
    chk("rst_inst", if_inst_o, ZERO_WORD);
    tick();
    rst = 1'b0;
    #1;
    // Cold miss
    chk("t1_req", {31'b0, mem_req_o}, 32'd1);
    chk("t1_stall_req", {31'b0, stall_req_o}, 32'd1);
    run_until_hold(20, cyc);
    chk("t1_cycles", cyc, 32'd4);
    chk_xfers("t1", 32'h0);
    chk_hold("t1", 32'h0, 32'h00500093);
    // Hit
    xfer_q.delete();
    jump_to(32'h0);
    chk("t2_req", {31'b0, mem_req_o}, 32'd0);
    chk("t2_fetch_inst", if_inst_o, ZERO_WORD);
    run_until_hold(20, cyc);
    chk("t2_cycles", cyc, 32'd1);
    chk("t2_nxfer", xfer_q.size(), 32'd0);
    chk_hold("t2", 32'h0, 32'h00500093);
    // Downstream stall
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_hold($sformatf("t3_frz%0d", i), 32'h0, 32'h00500093);
      chk($sformatf("t3_frz%0d_req", i), {31'b0, mem_req_o}, 32'd0);
    end
    stall_i = 6'h0;
    tick();
    stall_i = 6'h1;
    chk("t3_stall_req", {31'b0, stall_req_o}, 32'd1);
    chk("t3_pc_out", if_pc_o, ZERO_WORD);
    chk("t3_addr", mem_addr_o, 32'h4);
    // Jump mid-fetch
    xfer_q.delete();
    tick();
    chk("t4_nxfer_pre", xfer_q.size(), 32'd1);
    chk("t4_addr_pre", mem_addr_o, 32'h5);
    xfer_q.delete();
    jump_to(32'h100);
    chk("t4_req", {31'b0, mem_req_o}, 32'd1);
    chk("t4_addr", mem_addr_o, 32'h100);
    run_until_hold(20, cyc);
    chk("t4_cycles", cyc, 32'd4);
    chk_xfers("t4", 32'h100);
    chk_hold("t4", 32'h100, 32'hDEADBEEF);
    // Slow memory; the earlier partial word at 4 must not hit
    mem_lat = 5;
    jump_to(32'h4);
    chk("t5_miss", {31'b0, mem_req_o}, 32'd1);
    xfer_q.delete();
    unstable = 0;
    run_until_hold(100, cyc);
    chk("t5_cycles", cyc, 32'd24);
    chk_xfers("t5", 32'h4);
    chk("t5_addr_stable", unstable, 32'd0);
    chk_hold("t5", 32'h4, 32'h11223344);
    // Reset mid-fetch
    mem_lat = 0;
    jump_to(32'h40);
    tick();
    tick();
    chk("t6_addr_pre", mem_addr_o, 32'h42);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("t6_rst_stall_req", {31'b0, stall_req_o}, 32'd0);
    chk("t6_rst_inst", if_inst_o, ZERO_WORD);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_req", {31'b0, mem_req_o}, 32'd1);
    chk("t6_addr", mem_addr_o, 32'h0);
    chk("t6_inst", if_inst_o, ZERO_WORD);
    xfer_q.delete();
    run_until_hold(20, cyc);
    chk("t6_cycles", cyc, 32'd4);
    chk_hold("t6", 32'h0, 32'h00500093);
    jump_to(32'h40);
    chk("t6_miss40", {31'b0, mem_req_o}, 32'd1);
    run_until_hold(20, cyc);
    chk_hold("t6b", 32'h40, 32'hCAFEF00D);
    // PC wrap at the top of the address space
    jump_to(32'hFFFF_FFFC);
    run_until_hold(20, cyc);
    chk_hold("t7", 32'hFFFF_FFFC, 32'hA5A5_5A5A);
    stall_i = 6'h0;
    tick();
    stall_i = 6'h1;
    chk("t7_wrap_addr", mem_addr_o, 32'h0);
    chk("t7_wrap_hit", {31'b0, mem_req_o}, 32'd0);
    tick();
    chk_hold("t7w", 32'h0, 32'h00500093);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
